fetch_unit: RTL and testbench

Instruction fetch stage of the superscalar core: generates the sequential PC, issues requests to instruction memory, collects in-order responses and pushes {pc, instr} entries into the downstream instruction queue FIFO. A small internal response buffer plus credit accounting guarantees no response is ever lost while the queue is full. Redirects (branch/jump resolution) flush the queue and discard stale in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/fetch_resp_buf.sv | 56 +++++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared core constants and fetch entry type
package fetch_unit_pkg;

  localparam int CORE_XLEN = 32;
  localparam logic [CORE_XLEN-1:0] CORE_RESET_PC = '0;

  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_resp_buf.sv
// rtl/fetch_resp_buf.sv - circular response buffer with combinational head and clear
module fetch_resp_buf
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 2 * CORE_XLEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  logic [DW-1:0]                i_data,
  input  logic                         i_pop,
  output logic [DW-1:0]                o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [IW-1:0] r_wr_ptr;
  logic [IW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == LAST) ? '0 : p + IW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (i_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch with credit-limited issue and redirect flush
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int             XLEN            = CORE_XLEN,
  parameter logic [XLEN-1:0] RESET_PC       = XLEN'(CORE_RESET_PC),
  parameter int             MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [XLEN-1:0]   imem_resp_data,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [2*XLEN-1:0] fifo_din,
  output logic              flush_queue
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [IW-1:0] LAST = IW'(MAX_OUTSTANDING - 1);

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]       r_state;
  logic [XLEN-1:0]  r_pc;
  logic [CW-1:0]    r_outstanding;
  logic [CW-1:0]    r_stale;
  logic [XLEN-1:0]  r_tag [MAX_OUTSTANDING];
  logic [IW-1:0]    r_tag_wr;
  logic [IW-1:0]    r_tag_rd;

  logic [1:0]        w_state_next;
  logic [CW-1:0]     w_buf_count;
  logic              w_buf_empty;
  logic [2*XLEN-1:0] w_buf_head;
  logic              w_fifo_wr;
  logic [CW:0]       w_used;
  logic              w_accept;
  logic              w_resp_live;
  logic [CW-1:0]     w_out_next;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == LAST) ? '0 : p + IW'(1);
  endfunction

  assign w_fifo_wr = ~rst & ~w_buf_empty & ~fifo_full & ~halt & ~redirect_valid;

  // A slot freed by this cycle's drain can be re-used by this cycle's request,
  // which is what allows one instruction per cycle with a 1-cycle memory.
  assign w_used = {1'b0, r_outstanding} + {1'b0, w_buf_count} - {{CW{1'b0}}, w_fifo_wr};

  assign imem_req_valid = ~rst & (r_state == S_FETCH) & ~halt & ~redirect_valid
                        & (w_used < (CW+1)'(MAX_OUTSTANDING));
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid & imem_req_ready;

  assign w_resp_live = imem_resp_valid & (r_stale == '0) & ~redirect_valid;
  assign w_out_next  = r_outstanding + CW'(w_accept) - CW'(imem_resp_valid);

  assign w_state_next = halt ? S_HALT : S_FETCH;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_START;
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_stale       <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        r_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
        r_stale <= w_out_next;
      end else begin
        if (w_accept) r_pc <= r_pc + XLEN'(4);
        if (imem_resp_valid && r_stale != '0) r_stale <= r_stale - CW'(1);
      end
      // Tags track every in-flight request, stale or not, so they pop with each response.
      if (w_accept) begin
        r_tag[r_tag_wr] <= r_pc;
        r_tag_wr        <= ptr_inc(r_tag_wr);
      end
      if (imem_resp_valid) r_tag_rd <= ptr_inc(r_tag_rd);
    end
  end

  fetch_resp_buf #(
    .DEPTH (MAX_OUTSTANDING),
    .DW    (2 * XLEN)
  ) u_resp_buf (
    .clk     (clk),
    .rst     (rst),
    .i_clear (redirect_valid),
    .i_push  (w_resp_live),
    .i_data  ({r_tag[r_tag_rd], imem_resp_data}),
    .i_pop   (w_fifo_wr),
    .o_head  (w_buf_head),
    .o_count (w_buf_count),
    .o_empty (w_buf_empty)
  );

  assign fifo_wr_en  = w_fifo_wr;
  assign fifo_din    = w_buf_head;
  assign flush_queue = redirect_valid & ~rst;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with in-order memory model
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [63:0] fifo_din;
  logic        flush_queue;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN            (32),
    .RESET_PC        (32'h100),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .fifo_full       (fifo_full),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_din        (fifo_din),
    .flush_queue     (flush_queue)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  int base = 0;
  int flush_cnt = 0;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  logic [63:0] wr_din[$];
  int          wr_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_addr.size()) ? acc_addr[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic int acc_cyc_at(input int i);
    return (i < acc_cyc.size()) ? acc_cyc[i] : -1;
  endfunction

  function automatic logic [31:0] wr_pc(input int i);
    fetch_entry_t e;
    e = (i < wr_din.size()) ? wr_din[i] : '1;
    return e.pc;
  endfunction

  function automatic logic [31:0] wr_instr(input int i);
    fetch_entry_t e;
    e = (i < wr_din.size()) ? wr_din[i] : '1;
    return e.instr;
  endfunction

  function automatic int wr_cyc_at(input int i);
    return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe the current cycle at negedge, then advance and drive the memory response.
  task automatic cycle();
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      acc_addr.push_back(imem_req_addr);
      acc_cyc.push_back(cyc);
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + lat);
    end
    if (fifo_wr_en) begin
      wr_din.push_back(fifo_din);
      wr_cyc.push_back(cyc);
    end
    if (flush_queue) flush_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    halt = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    fifo_full = 1'b0;
    lat = l;
    mq_addr.delete();
    mq_due.delete();
    repeat (2) cycle();
    acc_addr.delete();
    acc_cyc.delete();
    wr_din.delete();
    wr_cyc.delete();
    flush_cnt = 0;
    rst = 1'b0;
    base = cyc;
  endtask

  initial begin
    rst = 1'b1;
    halt = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h500;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    fifo_full = 1'b0;

    // reset values, with halt and redirect asserted underneath reset
    repeat (2) cycle();
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 32'h100);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_din", fifo_din, 0);
    check("rst_flush", flush_queue, 0);

    // back-to-back fetch with 1-cycle memory
    do_reset(1);
    repeat (7) cycle();
    check("t1_acc0", acc_at(0), 32'h100);
    check("t1_acc1", acc_at(1), 32'h104);
    check("t1_acc2", acc_at(2), 32'h108);
    check("t1_first_req_cyc", acc_cyc_at(0), base + 1);
    check("t1_req_b2b", acc_cyc_at(2) - acc_cyc_at(0), 2);
    check("t1_wr0_pc", wr_pc(0), 32'h100);
    check("t1_wr1_pc", wr_pc(1), 32'h104);
    check("t1_wr2_pc", wr_pc(2), 32'h108);
    check("t1_wr0_instr", wr_instr(0), 32'hC0DE_0100);
    check("t1_first_wr_cyc", wr_cyc_at(0), base + 3);
    check("t1_wr_b2b", wr_cyc_at(2) - wr_cyc_at(0), 2);

    // queue full for 10 cycles
    do_reset(1);
    fifo_full = 1'b1;
    repeat (10) cycle();
    check("t2_req_count", acc_addr.size(), 2);
    check("t2_wr_count", wr_din.size(), 0);
    fifo_full = 1'b0;
    repeat (4) cycle();
    check("t2_wr0_pc", wr_pc(0), 32'h100);
    check("t2_wr1_pc", wr_pc(1), 32'h104);
    check("t2_wr_b2b", wr_cyc_at(1) - wr_cyc_at(0), 1);
    check("t2_resume_addr", acc_at(2), 32'h108);

    // memory not ready for 5 cycles
    do_reset(1);
    cycle();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_addr_held", imem_req_addr, 32'h100);
      check("t3_valid_held", imem_req_valid, 1);
      cycle();
    end
    check("t3_no_accept", acc_addr.size(), 0);
    check("t3_no_write", wr_din.size(), 0);
    imem_req_ready = 1'b1;
    repeat (4) cycle();
    check("t3_acc0", acc_at(0), 32'h100);
    check("t3_acc1", acc_at(1), 32'h104);

    // redirect with two requests in flight
    do_reset(3);
    repeat (3) cycle();
    check("t4_inflight", acc_addr.size(), 2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h2003;
    #1;
    check("t4_flush_pulse", flush_queue, 1);
    check("t4_no_req_on_redirect", imem_req_valid, 0);
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("t4_flush_drop", flush_queue, 0);
    check("t4_new_pc", imem_req_addr, 32'h2000);
    repeat (8) cycle();
    check("t4_acc_after", acc_at(2), 32'h2000);
    check("t4_wr0_pc", wr_pc(0), 32'h2000);
    check("t4_wr0_instr", wr_instr(0), 32'hC0DE_2000);
    check("t4_wr1_pc", wr_pc(1), 32'h2004);
    check("t4_wr0_cyc", wr_cyc_at(0), base + 9);
    check("t4_flush_count", flush_cnt, 1);

    // redirect in the same cycle as a response, one more request still in flight
    do_reset(2);
    repeat (3) cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h3000;
    cycle();
    redirect_valid = 1'b0;
    repeat (8) cycle();
    check("t5_acc_after", acc_at(2), 32'h3000);
    check("t5_wr0_pc", wr_pc(0), 32'h3000);
    check("t5_wr1_pc", wr_pc(1), 32'h3004);
    check("t5_wr0_cyc", wr_cyc_at(0), base + 7);

    // halt with two requests in flight
    do_reset(3);
    repeat (3) cycle();
    halt = 1'b1;
    repeat (7) cycle();
    #1;
    check("t6_req_count", acc_addr.size(), 2);
    check("t6_wr_count", wr_din.size(), 0);
    check("t6_wr_en_halted", fifo_wr_en, 0);
    check("t6_head_pc", fifo_din[63:32], 32'h100);
    halt = 1'b0;
    repeat (4) cycle();
    check("t6_wr0_pc", wr_pc(0), 32'h100);
    check("t6_wr1_pc", wr_pc(1), 32'h104);
    check("t6_wr_b2b", wr_cyc_at(1) - wr_cyc_at(0), 1);
    check("t6_resume_addr", acc_at(2), 32'h108);
    check("t6_resume_cyc", acc_cyc_at(2), base + 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
